// File: rtl/instruction_decode_if.sv
// Fetch/writeback-to-decode bus: upstream inputs, register-file write port
// and the registered ID stage outputs.
interface instruction_decode_if;
    logic        stall;
    logic        flush;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [31:0] id_imm_sext;
    logic [31:0] id_imm_zext;
    logic [31:0] id_jump_target;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;

    modport master (
        output stall, flush, if_pc, if_instruction, wb_en, wb_addr, wb_data,
        input  id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt,
        input  id_imm_sext, id_imm_zext, id_jump_target, id_rs_data, id_rt_data
    );

    modport slave (
        input  stall, flush, if_pc, if_instruction, wb_en, wb_addr, wb_data,
        output id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt,
        output id_imm_sext, id_imm_zext, id_jump_target, id_rs_data, id_rt_data
    );
endinterface

// File: rtl/instruction_decode.sv
// MIPS-style instruction decode stage: field split, immediate extension,
// jump target, 32x32 register file with write-through read, ID stage register.
module instruction_decode #(
    parameter logic [31:0] SP_INIT = 32'h7FFFEFFC,
    parameter logic [31:0] GP_INIT = 32'h10008000
) (
    input logic            clk,
    input logic            reset,
    instruction_decode_if.slave bus
);

    logic [31:0] regs [32];

    logic [5:0]  opcode_p0;
    logic [5:0]  funct_p0;
    logic [4:0]  rs_p0;
    logic [4:0]  rt_p0;
    logic [4:0]  rd_p0;
    logic [4:0]  shamt_p0;
    logic [31:0] imm_sext_p0;
    logic [31:0] imm_zext_p0;
    logic [31:0] pc_plus4_p0;
    logic [31:0] jump_target_p0;
    logic [31:0] rs_data_p0;
    logic [31:0] rt_data_p0;

    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [5:0]  opcode_p1;
    logic [5:0]  funct_p1;
    logic [4:0]  rs_p1;
    logic [4:0]  rt_p1;
    logic [4:0]  rd_p1;
    logic [4:0]  shamt_p1;
    logic [31:0] imm_sext_p1;
    logic [31:0] imm_zext_p1;
    logic [31:0] jump_target_p1;
    logic [31:0] rs_data_p1;
    logic [31:0] rt_data_p1;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

    // Register 0 is hardwired; a same-cycle writeback to the read index wins.
    function automatic logic [31:0] bypass_read(input logic [4:0]  idx,
                                                input logic [31:0] stored,
                                                input logic        wen,
                                                input logic [4:0]  waddr,
                                                input logic [31:0] wdata);
        logic [31:0] val;
        val = stored;
        if (idx == 5'd0)
            val = '0;
        else if (wen && (waddr == idx))
            val = wdata;
        return val;
    endfunction

    // Stage p0: combinational decode of the word offered by fetch
    always_comb begin
        opcode_p0      = bus.if_instruction[31:26];
        rs_p0          = bus.if_instruction[25:21];
        rt_p0          = bus.if_instruction[20:16];
        rd_p0          = bus.if_instruction[15:11];
        shamt_p0       = bus.if_instruction[10:6];
        funct_p0       = bus.if_instruction[5:0];
        imm_sext_p0    = sign_ext16(bus.if_instruction[15:0]);
        imm_zext_p0    = zero_ext16(bus.if_instruction[15:0]);
        pc_plus4_p0    = bus.if_pc + 32'd4;
        jump_target_p0 = {pc_plus4_p0[31:28], bus.if_instruction[25:0], 2'b00};
        rs_data_p0     = bypass_read(rs_p0, regs[rs_p0], bus.wb_en, bus.wb_addr, bus.wb_data);
        rt_data_p0     = bypass_read(rt_p0, regs[rt_p0], bus.wb_en, bus.wb_addr, bus.wb_data);
    end

    // Register file: writes proceed regardless of stall/flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                if (i == 28)
                    regs[i] <= GP_INIT;
                else if (i == 29)
                    regs[i] <= SP_INIT;
                else
                    regs[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Stage p1: ID stage register, flush > stall > capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset || bus.flush) begin
            vld_p1         <= 1'b0;
            pc_p1          <= '0;
            opcode_p1      <= '0;
            funct_p1       <= '0;
            rs_p1          <= '0;
            rt_p1          <= '0;
            rd_p1          <= '0;
            shamt_p1       <= '0;
            imm_sext_p1    <= '0;
            imm_zext_p1    <= '0;
            jump_target_p1 <= '0;
            rs_data_p1     <= '0;
            rt_data_p1     <= '0;
        end else if (!bus.stall) begin
            vld_p1         <= 1'b1;
            pc_p1          <= bus.if_pc;
            opcode_p1      <= opcode_p0;
            funct_p1       <= funct_p0;
            rs_p1          <= rs_p0;
            rt_p1          <= rt_p0;
            rd_p1          <= rd_p0;
            shamt_p1       <= shamt_p0;
            imm_sext_p1    <= imm_sext_p0;
            imm_zext_p1    <= imm_zext_p0;
            jump_target_p1 <= jump_target_p0;
            rs_data_p1     <= rs_data_p0;
            rt_data_p1     <= rt_data_p0;
        end
    end

    assign bus.id_valid       = vld_p1;
    assign bus.id_pc          = pc_p1;
    assign bus.id_opcode      = opcode_p1;
    assign bus.id_funct       = funct_p1;
    assign bus.id_rs          = rs_p1;
    assign bus.id_rt          = rt_p1;
    assign bus.id_rd          = rd_p1;
    assign bus.id_shamt       = shamt_p1;
    assign bus.id_imm_sext    = imm_sext_p1;
    assign bus.id_imm_zext    = imm_zext_p1;
    assign bus.id_jump_target = jump_target_p1;
    assign bus.id_rs_data     = rs_data_p1;
    assign bus.id_rt_data     = rt_data_p1;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed vector table, hand-written stall/flush/reset
// sequences and random traffic against an arithmetic reference model.
module tb_instruction_decode;

    localparam logic [31:0] SP_INIT = 32'h7FFFEFFC;
    localparam logic [31:0] GP_INIT = 32'h10008000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm_sext;
        logic [31:0] imm_zext;
        logic [31:0] jump_target;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } id_out_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        exp_valid;
        logic [4:0]  exp_rs;
        logic [31:0] exp_rs_data;
        logic [31:0] exp_rt_data;
        logic [31:0] exp_sext;
        logic [31:0] exp_zext;
        logic [31:0] exp_jt;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] model_regs [32];
    id_out_t     exp_q;
    id_out_t     held;
    vec_t        vecs [6];

    instruction_decode_if bus ();

    instruction_decode #(
        .SP_INIT(SP_INIT),
        .GP_INIT(GP_INIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_out_t actual();
        id_out_t a;
        a.valid       = bus.id_valid;
        a.pc          = bus.id_pc;
        a.opcode      = bus.id_opcode;
        a.funct       = bus.id_funct;
        a.rs          = bus.id_rs;
        a.rt          = bus.id_rt;
        a.rd          = bus.id_rd;
        a.shamt       = bus.id_shamt;
        a.imm_sext    = bus.id_imm_sext;
        a.imm_zext    = bus.id_imm_zext;
        a.jump_target = bus.id_jump_target;
        a.rs_data     = bus.id_rs_data;
        a.rt_data     = bus.id_rt_data;
        return a;
    endfunction

    // Reference: fields by division/modulo, extensions and target by plain arithmetic
    function automatic id_out_t model_capture(input logic [31:0] pc, input logic [31:0] ins,
                                              input logic [31:0] a, input logic [31:0] b);
        id_out_t r;
        logic [31:0] imm;
        logic [31:0] npc;
        r.valid       = 1'b1;
        r.pc          = pc;
        r.opcode      = 6'(ins / 32'h04000000);
        r.rs          = 5'((ins / 32'h00200000) % 32);
        r.rt          = 5'((ins / 32'h00010000) % 32);
        r.rd          = 5'((ins / 32'h00000800) % 32);
        r.shamt       = 5'((ins / 32'h00000040) % 32);
        r.funct       = 6'(ins % 64);
        imm           = ins % 65536;
        r.imm_zext    = imm;
        r.imm_sext    = (imm >= 32768) ? imm + 32'hFFFF0000 : imm;
        npc           = pc + 32'd4;
        r.jump_target = (npc & 32'hF0000000) | ((ins % 32'h04000000) * 4);
        r.rs_data     = a;
        r.rt_data     = b;
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wa == idx) return wd;
        return model_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_regs[28] = GP_INIT;
        model_regs[29] = SP_INIT;
        exp_q = '0;
    endtask

    task automatic check_all(input string name, input id_out_t want);
        id_out_t got;
        got = actual();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, predict the ID register, clock, then settle
    task automatic cycle(input logic st, input logic fl, input logic [31:0] pc,
                         input logic [31:0] ins, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        bus.stall          = st;
        bus.flush          = fl;
        bus.if_pc          = pc;
        bus.if_instruction = ins;
        bus.wb_en          = we;
        bus.wb_addr        = wa;
        bus.wb_data        = wd;
        if (fl)
            exp_q = '0;
        else if (!st)
            exp_q = model_capture(pc, ins,
                                  mread(5'((ins / 32'h00200000) % 32), we, wa, wd),
                                  mread(5'((ins / 32'h00010000) % 32), we, wa, wd));
        @(posedge clk);
        if (we && wa != 5'd0) model_regs[wa] = wd;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.if_pc = '0; bus.if_instruction = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        model_reset();

        //        st fl pc            instr         we wa    wd            v  rs     rs_data       rt_data       sext          zext          jt
        vecs[0] = '{0, 0, 32'h00400000, 32'h8FA80004, 0, 5'd0, 32'h0,        1, 5'd29, 32'h7FFFEFFC, 32'h00000000, 32'h00000004, 32'h00000004, 32'h0EA00010};
        vecs[1] = '{0, 0, 32'h00400004, 32'h2009FFFF, 0, 5'd0, 32'h0,        1, 5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0027FFFC};
        vecs[2] = '{0, 0, 32'h00400008, 32'h01205020, 1, 5'd9, 32'hDEADBEEF, 1, 5'd9,  32'hDEADBEEF, 32'h00000000, 32'h00005020, 32'h00005020, 32'h04814080};
        vecs[3] = '{0, 0, 32'h0040000C, 32'h00095020, 1, 5'd0, 32'h12345678, 1, 5'd0,  32'h00000000, 32'hDEADBEEF, 32'h00005020, 32'h00005020, 32'h00254080};
        vecs[4] = '{0, 0, 32'h0040FFFC, 32'h08100010, 0, 5'd0, 32'h0,        1, 5'd0,  32'h00000000, 32'h00000000, 32'h00000010, 32'h00000010, 32'h00400040};
        vecs[5] = '{0, 0, 32'hFFFFFFFC, 32'h0BFFFFFF, 0, 5'd0, 32'h0,        1, 5'd31, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0FFFFFFC};

        #2;
        check_all("reset_async_clear", '0);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h55555555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("reset_hold", '0);
        bus.wb_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].stall, vecs[i].flush, vecs[i].pc, vecs[i].instr,
                  vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
            check32($sformatf("vec%0d_valid", i), 32'(bus.id_valid), 32'(vecs[i].exp_valid));
            check32($sformatf("vec%0d_rs", i), 32'(bus.id_rs), 32'(vecs[i].exp_rs));
            check32($sformatf("vec%0d_rs_data", i), bus.id_rs_data, vecs[i].exp_rs_data);
            check32($sformatf("vec%0d_rt_data", i), bus.id_rt_data, vecs[i].exp_rt_data);
            check32($sformatf("vec%0d_sext", i), bus.id_imm_sext, vecs[i].exp_sext);
            check32($sformatf("vec%0d_zext", i), bus.id_imm_zext, vecs[i].exp_zext);
            check32($sformatf("vec%0d_jt", i), bus.id_jump_target, vecs[i].exp_jt);
            check32($sformatf("vec%0d_pc", i), bus.id_pc, vecs[i].pc);
            check_all($sformatf("vec%0d_model", i), exp_q);
        end

        // Stall three cycles with changing inputs and a register write underneath
        cycle(0, 0, 32'h00401000, 32'h01095820, 0, 5'd0, 32'h0);
        held = exp_q;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 32'h00402000 + 32'(i * 4), $urandom, (i == 1), 5'd5, 32'hCAFEF00D);
            check_all($sformatf("stall_hold%0d", i), held);
        end
        cycle(1, 1, 32'h00403000, 32'h8FA80004, 0, 5'd0, 32'h0);
        check_all("stall_flush_bubble", '0);
        cycle(0, 0, 32'h00403004, 32'h00A00000, 0, 5'd0, 32'h0);
        check32("write_during_stall", bus.id_rs_data, 32'hCAFEF00D);
        check_all("post_stall_model", exp_q);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            check_all($sformatf("rand%0d", i), exp_q);
        end

        // Asynchronous reset mid-stream
        cycle(0, 0, 32'h00404000, 32'h8FA80004, 0, 5'd0, 32'h0);
        check32("pre_reset_valid", 32'(bus.id_valid), 32'd1);
        #2;
        reset = 1'b1;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0BADF00D;
        #1;
        check_all("reset_midstream", '0);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        bus.wb_en = 1'b0;
        cycle(0, 0, 32'h00400000, 32'h039D0000, 0, 5'd0, 32'h0);
        check32("gp_after_reset", bus.id_rs_data, GP_INIT);
        check32("sp_after_reset", bus.id_rt_data, SP_INIT);
        check_all("post_reset_model", exp_q);
        cycle(0, 0, 32'h00400004, 32'h00A00000, 0, 5'd0, 32'h0);
        check32("reg5_cleared", bus.id_rs_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter SP_INIT, default 32'h7FFFEFFC, reset value of register 29 ($sp).
REQ-002 Parameter GP_INIT, default 32'h10008000, reset value of register 28 ($gp).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port stall  input  1  hold the ID stage register for this cycle.
REQ-006 Port flush  input  1  load a bubble into the ID stage register.
REQ-007 Port if_pc  input  32  PC of the instruction offered by fetch.
REQ-008 Port if_instruction  input  32  instruction word offered by fetch.
REQ-009 Port wb_en  input  1  register-file write enable from writeback.
REQ-010 Port wb_addr  input  5  register-file write index.
REQ-011 Port wb_data  input  32  register-file write data.
REQ-012 Port id_valid  output  1  ID stage register holds a real instruction.
REQ-013 Port id_pc  output  32  captured PC.
REQ-014 Port id_opcode / id_funct  output  6 each  instruction[31:26] / [5:0].
REQ-015 Port id_rs / id_rt / id_rd / id_shamt  output  5 each  instruction[25:21] / [20:16] / [15:11] / [10:6].
REQ-016 Port id_imm_sext / id_imm_zext  output  32 each  instruction[15:0] sign- / zero-extended.
REQ-017 Port id_jump_target  output  32  {pc_plus4[31:28], instruction[25:0], 2'b00}.
REQ-018 Port id_rs_data / id_rt_data  output  32 each  register operands read for rs / rt.

Function
REQ-019 Register file SHALL be 32 x 32 bits, written on rising clk when wb_en=1 and wb_addr!=0.
REQ-020 Register 0 SHALL read as 0 always; writes to index 0 SHALL be ignored.
REQ-021 Register reads SHALL be combinational from if_instruction rs/rt fields, then registered into id_rs_data/id_rt_data.
REQ-022 Write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr equals the read index in the same cycle, the read SHALL return wb_data.
REQ-023 All id_* outputs SHALL be registered; latency from if_* to id_* SHALL be exactly one clock.
REQ-024 Priority per rising edge: flush > stall > normal capture.
REQ-025 flush=1: id_valid<=0 and all other id_* outputs <=0 (NOP bubble), regardless of stall.
REQ-026 stall=1, flush=0: all id_* outputs SHALL hold their values.
REQ-027 Held operands SHALL NOT refresh during stall; the upstream hazard unit owns that refresh.
REQ-028 Normal capture: id_valid<=1 and all fields, extensions, target and operands loaded from the current if_* inputs.
REQ-029 Register-file writes SHALL occur independently of stall and flush.
REQ-030 pc_plus4 SHALL be if_pc+4 modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.

Reset
REQ-031 reset=1 SHALL immediately clear id_valid and every id_* output to 0, independent of clk.
REQ-032 reset=1 SHALL set every register to 0 except register 28 = GP_INIT and register 29 = SP_INIT.
REQ-033 While reset=1, wb_en SHALL have no effect; the first capture occurs on the first rising edge after reset falls.

Verification
REQ-034 Reset, then if_instruction=32'h8FA80004 (lw $8,4($sp)), if_pc=32'h00400000 -> next edge: id_valid=1, id_rs=29, id_rt=8, id_imm_sext=4, id_rs_data=32'h7FFFEFFC.
REQ-035 Offer 32'h2009FFFF -> id_imm_sext=32'hFFFFFFFF, id_imm_zext=32'h0000FFFF.
REQ-036 Same cycle: wb_en=1, wb_addr=9, wb_data=32'hDEADBEEF, instruction reads rs=9 -> id_rs_data=32'hDEADBEEF; also wb_addr=0 write -> reg 0 still reads 0.
REQ-037 stall=1 for 3 cycles with if_* changing each cycle -> id_* unchanged; stall=flush=1 -> id_valid=0, all outputs 0.
REQ-038 if_pc=32'h0040FFFC, if_instruction=32'h08100010 (j) -> id_jump_target=32'h00400040.
REQ-039 Assert reset asynchronously mid-stream with id_valid=1 -> id_valid=0 before the next edge; reg 28 reads 32'h10008000 after release.
